seg7_scan_mux: RTL

SEG7_SCAN_MUX -- requirements
Module: seg7_scan_mux

---
 rtl/seg7_scan_mux.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/seg7_scan_mux.sv
// Four-digit seven-segment scanner with blanking gaps between digits and a synchronized DP select.
// Optional leading-zero suppression is enabled by defining LEADING_ZERO_BLANK_EN.
module seg7_scan_mux #(
    parameter int CLK_DIV   = 100000,
    parameter int BLANK_CYC = 16
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [15:0] SW,
    input  logic [1:0]  BTN,
    output logic [3:0]  AN,
    output logic [6:0]  CAT,
    output logic        DP,
    output logic [3:0]  LED
);

    localparam int CNT_MAX = (CLK_DIV > BLANK_CYC) ? CLK_DIV : BLANK_CYC;
    localparam int CW      = $clog2(CNT_MAX);

    typedef enum logic {BLANK = 1'b0, DRIVE = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    snap_q, snap_d;
    logic [1:0]    btn_meta_q, btn_sync_q;
    logic [3:0]    an_q, an_d;
    logic [6:0]    cat_q, cat_d;
    logic          dp_q, dp_d;
    logic [3:0]    led_q, led_d;
`ifdef LEADING_ZERO_BLANK_EN
    logic          lz_q, lz_d;
`endif

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            4'hF: s = 7'b0001110;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Next-state logic; outputs are derived from the next state so AN and CAT switch together.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        idx_d   = idx_q;
        snap_d  = snap_q;
`ifdef LEADING_ZERO_BLANK_EN
        lz_d    = lz_q;
`endif
        case (state_q)
            BLANK: begin
                if (cnt_q == CW'(BLANK_CYC - 1)) begin
                    state_d = DRIVE;
                    cnt_d   = '0;
                    idx_d   = idx_q + 2'd1;
                    snap_d  = SW[{idx_d, 2'b00} +: 4];
`ifdef LEADING_ZERO_BLANK_EN
                    lz_d    = (idx_d != 2'd0) && ((SW >> {idx_d, 2'b00}) == 16'h0000);
`endif
                end else begin
                    state_d = BLANK;
                end
            end
            DRIVE: begin
                if (cnt_q == CW'(CLK_DIV - 1)) begin
                    state_d = BLANK;
                    cnt_d   = '0;
                end else begin
                    state_d = DRIVE;
                end
            end
            default: begin
                state_d = BLANK;
                cnt_d   = '0;
            end
        endcase

        if (state_d == DRIVE) begin
`ifdef LEADING_ZERO_BLANK_EN
            an_d  = lz_d ? 4'b1111 : ~(4'b0001 << idx_d);
            cat_d = lz_d ? 7'b1111111 : hex7(snap_d);
            dp_d  = (lz_d || (idx_d != btn_sync_q)) ? 1'b1 : 1'b0;
`else
            an_d  = ~(4'b0001 << idx_d);
            cat_d = hex7(snap_d);
            dp_d  = (idx_d == btn_sync_q) ? 1'b0 : 1'b1;
`endif
            led_d = 4'b0001 << idx_d;
        end else begin
            an_d  = 4'b1111;
            cat_d = 7'b1111111;
            dp_d  = 1'b1;
            led_d = 4'b0000;
        end
    end

    // State, prescaler, BTN synchronizer and registered outputs.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q    <= BLANK;
            cnt_q      <= '0;
            idx_q      <= 2'd3;
            snap_q     <= 4'h0;
            btn_meta_q <= 2'b00;
            btn_sync_q <= 2'b00;
            an_q       <= 4'b1111;
            cat_q      <= 7'b1111111;
            dp_q       <= 1'b1;
            led_q      <= 4'b0000;
`ifdef LEADING_ZERO_BLANK_EN
            lz_q       <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            snap_q     <= snap_d;
            btn_meta_q <= BTN;
            btn_sync_q <= btn_meta_q;
            an_q       <= an_d;
            cat_q      <= cat_d;
            dp_q       <= dp_d;
            led_q      <= led_d;
`ifdef LEADING_ZERO_BLANK_EN
            lz_q       <= lz_d;
`endif
        end
    end

    assign AN  = an_q;
    assign CAT = cat_q;
    assign DP  = dp_q;
    assign LED = led_q;

endmodule
